// File: rtl/clause_stream_loader_pkg.sv
// Shared formula/clause/literal types and the loader FSM encoding.
package clause_stream_loader_pkg;

    localparam int unsigned number_literal    = 4;
    localparam int unsigned number_clauses    = 4;
    localparam int unsigned width_litarray    = $clog2(number_literal);
    localparam int unsigned width_clausearray = $clog2(number_clauses);

    typedef struct packed {
        logic [width_litarray:0] num;
        logic                    val;
    } literal_t;

    typedef struct packed {
        literal_t [number_literal-1:0] lits;
        logic [width_litarray:0]       len;
    } clause_t;

    typedef struct packed {
        clause_t [number_clauses-1:0] clauses;
        logic [width_clausearray:0]   len;
    } formula_t;

    localparam formula_t zero_formula = '0;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, PUBLISH} loader_state_t;

endpackage

// File: rtl/clause_stream_loader_lit_lane_scan.sv
// Combinational scan of SCAN_LANES literal positions: per-lane literals, counts and slot offsets.
module clause_stream_loader_lit_lane_scan
    import clause_stream_loader_pkg::*;
#(
    parameter int unsigned SCAN_LANES = 1,
    parameter bit          DROP_TAUT  = 1'b1,
    parameter int unsigned LaneCntW   = $clog2(2 * SCAN_LANES + 1)
) (
    input  logic [SCAN_LANES-1:0] pos_i,
    input  logic [SCAN_LANES-1:0] neg_i,
    input  logic [width_litarray:0] base_i,
    output literal_t              lit_a_o   [SCAN_LANES],
    output literal_t              lit_b_o   [SCAN_LANES],
    output logic [1:0]            lit_cnt_o [SCAN_LANES],
    output logic [SCAN_LANES-1:0] lit_vld_o,
    output logic [LaneCntW-1:0]   prefix_o  [SCAN_LANES],
    output logic                  taut_o,
    output logic [LaneCntW-1:0]   total_o
);

    localparam int unsigned LW = width_litarray + 1;

    logic [LaneCntW-1:0] run;

    always_comb begin
        run    = '0;
        taut_o = 1'b0;
        for (int i = 0; i < SCAN_LANES; i++) begin
            lit_a_o[i].num = base_i + LW'(i + 1);
            lit_a_o[i].val = pos_i[i];
            lit_b_o[i].num = base_i + LW'(i + 1);
            lit_b_o[i].val = 1'b0;
            if (pos_i[i] && neg_i[i]) begin
                taut_o       = 1'b1;
                // Kept tautologies emit x then not-x in two consecutive slots.
                lit_cnt_o[i] = DROP_TAUT ? 2'd0 : 2'd2;
            end else begin
                lit_cnt_o[i] = (pos_i[i] || neg_i[i]) ? 2'd1 : 2'd0;
            end
            lit_vld_o[i] = (lit_cnt_o[i] != 2'd0);
            prefix_o[i]  = run;
            run          = run + LaneCntW'(lit_cnt_o[i]);
        end
        total_o = run;
    end

endmodule

// File: rtl/clause_stream_loader.sv
// Valid/ready clause loader: scans each clause beat into the working formula and
// publishes it with a done pulse after the last beat.
module clause_stream_loader
    import clause_stream_loader_pkg::*;
#(
    parameter int unsigned NUM_LIT     = number_literal,
    parameter int unsigned MAX_CLAUSES = number_clauses,
    parameter int unsigned SCAN_LANES  = 1,
    parameter bit          DROP_TAUT   = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_LIT-1:0] in_pos,
    input  logic [NUM_LIT-1:0] in_neg,
    input  logic               in_last,
    output formula_t           formula_res,
    output logic               done,
    output logic               err_taut,
    output logic               err_overflow
);

    localparam int unsigned Chunks   = NUM_LIT / SCAN_LANES;
    localparam int unsigned ChunkW   = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam int unsigned CntW     = $clog2(2 * NUM_LIT + 1);
    localparam int unsigned LaneCntW = $clog2(2 * SCAN_LANES + 1);
    localparam int unsigned LitCap   = number_literal;
    localparam int unsigned LW       = width_litarray + 1;
    localparam int unsigned KeptW    = width_clausearray + 1;

    loader_state_t      state_q, state_d;
    logic [NUM_LIT-1:0] pos_q, pos_d, neg_q, neg_d;
    logic               last_q, last_d, taut_q, taut_d;
    logic [ChunkW-1:0]  chunk_q, chunk_d;
    clause_t            clause_q, clause_d;
    logic [CntW-1:0]    lit_cnt_q, lit_cnt_d;
    formula_t           work_q, work_d, formula_res_q, formula_res_d;
    logic [KeptW-1:0]   kept_q, kept_d;
    logic               err_taut_w_q, err_taut_w_d, err_ovf_w_q, err_ovf_w_d;
    logic               done_q, done_d, err_taut_q, err_taut_d, err_ovf_q, err_ovf_d;

    logic [SCAN_LANES-1:0] lane_pos, lane_neg, lane_vld;
    literal_t              lane_lit_a [SCAN_LANES];
    literal_t              lane_lit_b [SCAN_LANES];
    logic [1:0]            lane_cnt   [SCAN_LANES];
    logic [LaneCntW-1:0]   lane_pre   [SCAN_LANES];
    logic [LaneCntW-1:0]   lane_total;
    logic                  lane_taut;
    logic [CntW-1:0]       slot;

    assign lane_pos = SCAN_LANES'(pos_q >> (32'(chunk_q) * SCAN_LANES));
    assign lane_neg = SCAN_LANES'(neg_q >> (32'(chunk_q) * SCAN_LANES));

    clause_stream_loader_lit_lane_scan #(
        .SCAN_LANES (SCAN_LANES),
        .DROP_TAUT  (DROP_TAUT),
        .LaneCntW   (LaneCntW)
    ) u_lane_scan (
        .pos_i     (lane_pos),
        .neg_i     (lane_neg),
        .base_i    (LW'(32'(chunk_q) * SCAN_LANES)),
        .lit_a_o   (lane_lit_a),
        .lit_b_o   (lane_lit_b),
        .lit_cnt_o (lane_cnt),
        .lit_vld_o (lane_vld),
        .prefix_o  (lane_pre),
        .taut_o    (lane_taut),
        .total_o   (lane_total)
    );

    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        neg_d         = neg_q;
        last_d        = last_q;
        taut_d        = taut_q;
        chunk_d       = chunk_q;
        clause_d      = clause_q;
        lit_cnt_d     = lit_cnt_q;
        work_d        = work_q;
        kept_d        = kept_q;
        err_taut_w_d  = err_taut_w_q;
        err_ovf_w_d   = err_ovf_w_q;
        formula_res_d = formula_res_q;
        err_taut_d    = err_taut_q;
        err_ovf_d     = err_ovf_q;
        done_d        = 1'b0;
        slot          = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pos_d     = in_pos;
                    neg_d     = in_neg;
                    last_d    = in_last;
                    taut_d    = 1'b0;
                    chunk_d   = '0;
                    clause_d  = '0;
                    lit_cnt_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                for (int i = 0; i < SCAN_LANES; i++) begin
                    // Slots past the clause capacity are silently discarded.
                    slot = lit_cnt_q + CntW'(lane_pre[i]);
                    if (lane_vld[i] && slot < CntW'(LitCap)) begin
                        clause_d.lits[slot[width_litarray-1:0]] = lane_lit_a[i];
                    end
                    slot = slot + 1'b1;
                    if (lane_cnt[i] == 2'd2 && slot < CntW'(LitCap)) begin
                        clause_d.lits[slot[width_litarray-1:0]] = lane_lit_b[i];
                    end
                end
                lit_cnt_d = lit_cnt_q + CntW'(lane_total);
                taut_d    = taut_q | lane_taut;
                chunk_d   = chunk_q + 1'b1;
                if (chunk_q == ChunkW'(Chunks - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                err_taut_w_d = err_taut_w_q | taut_q;
                if (lit_cnt_q != '0 && !(taut_q && DROP_TAUT)) begin
                    if (kept_q < KeptW'(MAX_CLAUSES)) begin
                        work_d.clauses[kept_q[width_clausearray-1:0]].lits = clause_q.lits;
                        work_d.clauses[kept_q[width_clausearray-1:0]].len =
                            (lit_cnt_q > CntW'(LitCap)) ? LW'(LitCap) : LW'(lit_cnt_q);
                        kept_d = kept_q + 1'b1;
                    end else begin
                        err_ovf_w_d = 1'b1;
                    end
                end
                state_d = last_q ? PUBLISH : IDLE;
            end
            PUBLISH: begin
                formula_res_d     = work_q;
                formula_res_d.len = kept_q;
                err_taut_d        = err_taut_w_q;
                err_ovf_d         = err_ovf_w_q;
                done_d            = 1'b1;
                work_d            = '0;
                kept_d            = '0;
                err_taut_w_d      = 1'b0;
                err_ovf_w_d       = 1'b0;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pos_q         <= '0;
            neg_q         <= '0;
            last_q        <= 1'b0;
            taut_q        <= 1'b0;
            chunk_q       <= '0;
            clause_q      <= '0;
            lit_cnt_q     <= '0;
            work_q        <= zero_formula;
            kept_q        <= '0;
            err_taut_w_q  <= 1'b0;
            err_ovf_w_q   <= 1'b0;
            formula_res_q <= zero_formula;
            err_taut_q    <= 1'b0;
            err_ovf_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            neg_q         <= neg_d;
            last_q        <= last_d;
            taut_q        <= taut_d;
            chunk_q       <= chunk_d;
            clause_q      <= clause_d;
            lit_cnt_q     <= lit_cnt_d;
            work_q        <= work_d;
            kept_q        <= kept_d;
            err_taut_w_q  <= err_taut_w_d;
            err_ovf_w_q   <= err_ovf_w_d;
            formula_res_q <= formula_res_d;
            err_taut_q    <= err_taut_d;
            err_ovf_q     <= err_ovf_d;
            done_q        <= done_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign formula_res  = formula_res_q;
    assign done         = done_q;
    assign err_taut     = err_taut_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_clause_stream_loader.sv
// Randomized bench for clause_stream_loader: three configurations against a list-based formula model.
module tb_clause_stream_loader;
    import clause_stream_loader_pkg::*;

    localparam int NDut = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid     [NDut];
    logic       in_ready     [NDut];
    logic [3:0] in_pos       [NDut];
    logic [3:0] in_neg       [NDut];
    logic       in_last      [NDut];
    formula_t   formula_res  [NDut];
    logic       done         [NDut];
    logic       err_taut     [NDut];
    logic       err_overflow [NDut];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_cnt [NDut];

    logic [3:0] sp [16];
    logic [3:0] sn [16];
    int         nb;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NDut; i++) begin
            if (!reset && in_valid[i] && in_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
        end
    end

    // Configurations: 0 = (1 lane, drop taut), 1 = (1 lane, keep taut), 2 = (2 lanes, drop taut)
    clause_stream_loader #(.SCAN_LANES(1), .DROP_TAUT(1'b1)) u_dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_pos(in_pos[0]), .in_neg(in_neg[0]), .in_last(in_last[0]),
        .formula_res(formula_res[0]), .done(done[0]), .err_taut(err_taut[0]),
        .err_overflow(err_overflow[0]));
    clause_stream_loader #(.SCAN_LANES(1), .DROP_TAUT(1'b0)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_pos(in_pos[1]), .in_neg(in_neg[1]), .in_last(in_last[1]),
        .formula_res(formula_res[1]), .done(done[1]), .err_taut(err_taut[1]),
        .err_overflow(err_overflow[1]));
    clause_stream_loader #(.SCAN_LANES(2), .DROP_TAUT(1'b1)) u_dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_pos(in_pos[2]), .in_neg(in_neg[2]), .in_last(in_last[2]),
        .formula_res(formula_res[2]), .done(done[2]), .err_taut(err_taut[2]),
        .err_overflow(err_overflow[2]));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: build each clause as a literal list, then apply drop/capacity rules.
    function automatic void model(input int dt, output formula_t f, output logic et,
                                  output logic eo);
        int kept = 0;
        f  = zero_formula;
        et = 1'b0;
        eo = 1'b0;
        for (int c = 0; c < nb; c++) begin
            literal_t lits[$];
            literal_t l;
            bit       taut = 0;
            for (int k = 0; k < 4; k++) begin
                l.num = 3'(k + 1);
                if (sp[c][k] && sn[c][k]) begin
                    taut = 1;
                    if (dt == 0) begin
                        l.val = 1'b1; lits.push_back(l);
                        l.val = 1'b0; lits.push_back(l);
                    end
                end else if (sp[c][k]) begin
                    l.val = 1'b1; lits.push_back(l);
                end else if (sn[c][k]) begin
                    l.val = 1'b0; lits.push_back(l);
                end
            end
            if (taut) et = 1'b1;
            if (lits.size() == 0 || (taut && dt != 0)) continue;
            if (kept == 4) begin
                eo = 1'b1;
                continue;
            end
            for (int j = 0; j < lits.size() && j < 4; j++) f.clauses[kept].lits[j] = lits[j];
            f.clauses[kept].len = 3'((lits.size() > 4) ? 4 : lits.size());
            kept++;
        end
        f.len = 3'(kept);
    endfunction

    // Streams sp/sn[0..nb-1] into one DUT with valid held high, then checks the publish.
    task automatic run_formula(input int idx, output formula_t got);
        int       per = (idx == 2) ? 4 : 6;
        int       dt  = (idx == 1) ? 0 : 1;
        int       t_prev = 0, t_acc = 0, wc, acc0;
        formula_t ef;
        logic     et, eo;
        model(dt, ef, et, eo);
        acc0 = acc_cnt[idx];
        got  = zero_formula;
        for (int b = 0; b < nb; b++) begin
            in_valid[idx] = 1'b1;
            in_pos[idx]   = sp[b];
            in_neg[idx]   = sn[b];
            in_last[idx]  = (b == nb - 1);
            wc = 0;
            while (!in_ready[idx] && wc < 100) begin
                @(negedge clock);
                wc++;
            end
            if (!in_ready[idx]) begin
                check_eq("ready_timeout", 0, 1);
                in_valid[idx] = 1'b0;
                return;
            end
            @(negedge clock);
            t_acc = cyc;
            if (b > 0) check_eq("beat_spacing", 128'(t_acc - t_prev), 128'(per));
            t_prev = t_acc;
        end
        in_valid[idx] = 1'b0;
        wc = 0;
        while (!done[idx] && wc < 200) begin
            @(negedge clock);
            wc++;
        end
        check_eq("done_seen", done[idx], 1);
        check_eq("done_latency", 128'(cyc - t_acc), 128'(per));
        got = formula_res[idx];
        check_eq("formula", formula_res[idx], ef);
        check_eq("err_taut", err_taut[idx], et);
        check_eq("err_overflow", err_overflow[idx], eo);
        @(negedge clock);
        check_eq("done_pulse", done[idx], 0);
        check_eq("accept_count", 128'(acc_cnt[idx] - acc0), 128'(nb));
        repeat (3) @(negedge clock);
        check_eq("formula_hold", formula_res[idx], ef);
    endtask

    initial begin
        formula_t exp_f, got_f;
        reset = 1'b1;
        for (int i = 0; i < NDut; i++) begin
            in_valid[i] = 1'b0; in_pos[i] = '0; in_neg[i] = '0; in_last[i] = 1'b0;
            acc_cnt[i]  = 0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < NDut; i++) begin
            check_eq("rst_formula", formula_res[i], zero_formula);
            check_eq("rst_ready", in_ready[i], 1);
            check_eq("rst_done", done[i], 0);
            check_eq("rst_errs", {err_taut[i], err_overflow[i]}, 0);
        end
        reset = 1'b0;
        @(negedge clock);

        // Single clause x1 | ~x3.
        nb = 1; sp[0] = 4'b0001; sn[0] = 4'b0100;
        run_formula(0, got_f);
        exp_f = zero_formula;
        exp_f.len = 3'd1;
        exp_f.clauses[0].len = 3'd2;
        exp_f.clauses[0].lits[0] = '{num: 3'd1, val: 1'b1};
        exp_f.clauses[0].lits[1] = '{num: 3'd3, val: 1'b0};
        check_eq("single_direct", got_f, exp_f);

        // Empty middle clause is dropped.
        nb = 3;
        sp[0] = 4'b1000; sn[0] = 4'b0001;
        sp[1] = 4'b0000; sn[1] = 4'b0000;
        sp[2] = 4'b0010; sn[2] = 4'b0000;
        run_formula(0, got_f);
        check_eq("empty_drop_len", got_f.len, 2);

        // Tautology dropped vs kept.
        nb = 1; sp[0] = 4'b0100; sn[0] = 4'b0110;
        run_formula(0, got_f);
        check_eq("taut_drop_len", got_f.len, 0);
        run_formula(1, got_f);
        exp_f = zero_formula;
        exp_f.len = 3'd1;
        exp_f.clauses[0].len = 3'd3;
        exp_f.clauses[0].lits[0] = '{num: 3'd2, val: 1'b0};
        exp_f.clauses[0].lits[1] = '{num: 3'd3, val: 1'b1};
        exp_f.clauses[0].lits[2] = '{num: 3'd3, val: 1'b0};
        check_eq("taut_keep_direct", got_f, exp_f);

        // Overflow, then a clean follow-up formula.
        nb = 5;
        for (int b = 0; b < 5; b++) begin
            sp[b] = 4'(b + 1); sn[b] = 4'b0000;
        end
        run_formula(0, got_f);
        check_eq("ovf_len", got_f.len, 4);
        check_eq("ovf_flag", err_overflow[0], 1);
        nb = 1; sp[0] = 4'b0000; sn[0] = 4'b1001;
        run_formula(0, got_f);
        check_eq("ovf_cleared", err_overflow[0], 0);

        // Two-lane backpressure run, same rules as one lane.
        nb = 3;
        sp[0] = 4'b0101; sn[0] = 4'b1010;
        sp[1] = 4'b0011; sn[1] = 4'b0100;
        sp[2] = 4'b1000; sn[2] = 4'b0001;
        run_formula(2, got_f);

        // Reset in the middle of a scan.
        in_valid[0] = 1'b1; in_pos[0] = 4'b0001; in_neg[0] = 4'b0000; in_last[0] = 1'b1;
        @(negedge clock);
        in_valid[0] = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_eq("midscan_formula", formula_res[0], zero_formula);
        check_eq("midscan_done", done[0], 0);
        check_eq("midscan_ready", in_ready[0], 1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        nb = 1; sp[0] = 4'b0010; sn[0] = 4'b1000;
        run_formula(0, got_f);

        // Random formulas on every configuration.
        for (int r = 0; r < 10; r++) begin
            for (int idx = 0; idx < NDut; idx++) begin
                nb = $urandom_range(1, 6);
                for (int b = 0; b < nb; b++) begin
                    sp[b] = 4'($urandom);
                    sn[b] = 4'($urandom);
                    if ($urandom_range(0, 2) != 0) sn[b] = sn[b] & ~sp[b];
                    if ($urandom_range(0, 7) == 0) begin
                        sp[b] = '0; sn[b] = '0;
                    end
                end
                run_formula(idx, got_f);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
